glb_store_dma: RTL and testbench

- Store-side DMA for one global buffer tile.
- Takes 16-bit CGRA stream words and packs them into 64-bit bank words, emitting SRAM write packets (wr_en, wr_strb, wr_addr, wr_data) to the tile's bank switch.
- Execution is driven by store headers (valid, start_addr, num_words) pushed by the config block into an internal queue.

---
 rtl/glb_store_dma_if.sv | 36 +++
 rtl/glb_store_dma.sv | 176 +++++++++++++++++
 tb/tb_glb_store_dma.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/glb_store_dma_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : glb_store_dma_if                                                |
// | Brief    : Header-push, stream-input and SRAM write-packet bundle.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface glb_store_dma_if #(
  parameter int GLB_ADDR_WIDTH      = 22,
  parameter int MAX_NUM_WORDS_WIDTH = 21,
  parameter int BANK_DATA_WIDTH     = 64,
  parameter int CGRA_DATA_WIDTH     = 16
) ();
  logic                             hdr_push;
  logic [GLB_ADDR_WIDTH-1:0]        hdr_start_addr;
  logic [MAX_NUM_WORDS_WIDTH-1:0]   hdr_num_words;
  logic                             hdr_full;
  logic [2:0]                       hdr_count;
  logic [CGRA_DATA_WIDTH-1:0]       stream_data;
  logic                             stream_data_valid;
  logic                             wr_en;
  logic [BANK_DATA_WIDTH/8-1:0]     wr_strb;
  logic [GLB_ADDR_WIDTH-1:0]        wr_addr;
  logic [BANK_DATA_WIDTH-1:0]       wr_data;
  logic                             st_done_pulse;

  modport master (
    output hdr_push, hdr_start_addr, hdr_num_words, stream_data, stream_data_valid,
    input  hdr_full, hdr_count, wr_en, wr_strb, wr_addr, wr_data, st_done_pulse
  );

  modport slave (
    input  hdr_push, hdr_start_addr, hdr_num_words, stream_data, stream_data_valid,
    output hdr_full, hdr_count, wr_en, wr_strb, wr_addr, wr_data, st_done_pulse
  );
endinterface
`default_nettype wire

// File: rtl/glb_store_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : glb_store_dma                                                   |
// | Brief    : Store DMA packing 16-bit stream words into 64-bit SRAM writes.  |
// |            Define GLB_ST_DMA_DROP_CNT_EN to add the drop_cnt output.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module glb_store_dma #(
  parameter int GLB_ADDR_WIDTH      = 22,
  parameter int MAX_NUM_WORDS_WIDTH = 21,
  parameter int QUEUE_DEPTH         = 4,
  parameter int BANK_DATA_WIDTH     = 64,
  parameter int CGRA_DATA_WIDTH     = 16
) (
  input  logic           clk,
  input  logic           reset,
  glb_store_dma_if.slave bus
`ifdef GLB_ST_DMA_DROP_CNT_EN
  ,
  output logic [15:0]    drop_cnt
`endif
);

  localparam int STRB_W     = BANK_DATA_WIDTH / 8;
  localparam int LANES      = BANK_DATA_WIDTH / CGRA_DATA_WIDTH;
  localparam int LANE_W     = $clog2(LANES);
  localparam int LANE_BYTES = CGRA_DATA_WIDTH / 8;
  localparam int OFFS_W     = $clog2(STRB_W);
  localparam int PTR_W      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [2:0]        DEPTH_C   = 3'(QUEUE_DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  logic [GLB_ADDR_WIDTH-1:0]      q_addr [QUEUE_DEPTH];
  logic [MAX_NUM_WORDS_WIDTH-1:0] q_num  [QUEUE_DEPTH];
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [2:0]                     count;

  state_t                         state;
  logic [GLB_ADDR_WIDTH-1:0]      cur_addr;
  logic [LANE_W-1:0]              lane;
  logic [MAX_NUM_WORDS_WIDTH-1:0] remaining;
  logic [BANK_DATA_WIDTH-1:0]     pack_data;
  logic [BANK_DATA_WIDTH-1:0]     pack_data_nxt;
  logic [STRB_W-1:0]              pack_strb;
  logic [STRB_W-1:0]              pack_strb_nxt;

  logic push_ok;
  logic pop;
  logic accept;
  logic last_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Push admission uses the pre-pop count, so a push while full is lost
  // even when the FSM pops in the same cycle.
  assign bus.hdr_full  = (count == DEPTH_C);
  assign bus.hdr_count = count;
  assign push_ok       = bus.hdr_push && !bus.hdr_full;
  assign pop           = (state == LOAD);
  assign accept        = (state == ACTIVE) && bus.stream_data_valid;
  assign last_word     = (remaining == MAX_NUM_WORDS_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        q_addr[wr_ptr] <= bus.hdr_start_addr & ~GLB_ADDR_WIDTH'(1);
        q_num[wr_ptr]  <= bus.hdr_num_words;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push_ok && !pop) begin
        count <= count + 3'd1;
      end else if (!push_ok && pop) begin
        count <= count - 3'd1;
      end
    end
  end

  always_comb begin
    pack_data_nxt = pack_data;
    pack_strb_nxt = pack_strb;
    pack_data_nxt[lane*CGRA_DATA_WIDTH +: CGRA_DATA_WIDTH] = bus.stream_data;
    pack_strb_nxt[lane*LANE_BYTES +: LANE_BYTES]           = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cur_addr          <= '0;
      lane              <= '0;
      remaining         <= '0;
      pack_data         <= '0;
      pack_strb         <= '0;
      bus.wr_en         <= 1'b0;
      bus.wr_strb       <= '0;
      bus.wr_addr       <= '0;
      bus.wr_data       <= '0;
      bus.st_done_pulse <= 1'b0;
    end else begin
      bus.wr_en         <= 1'b0;
      bus.st_done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (count != 3'd0) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          cur_addr  <= q_addr[rd_ptr];
          lane      <= q_addr[rd_ptr][LANE_W:1];
          remaining <= q_num[rd_ptr];
          pack_data <= '0;
          pack_strb <= '0;
          if (q_num[rd_ptr] == '0) begin
            bus.st_done_pulse <= 1'b1;
            state             <= IDLE;
          end else begin
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if ((lane == LAST_LANE) || last_word) begin
              bus.wr_en   <= 1'b1;
              bus.wr_addr <= {cur_addr[GLB_ADDR_WIDTH-1:OFFS_W], OFFS_W'(0)};
              bus.wr_data <= pack_data_nxt;
              bus.wr_strb <= pack_strb_nxt;
              pack_data   <= '0;
              pack_strb   <= '0;
              cur_addr    <= cur_addr + GLB_ADDR_WIDTH'(STRB_W);
              lane        <= '0;
            end else begin
              pack_data <= pack_data_nxt;
              pack_strb <= pack_strb_nxt;
              lane      <= lane + 1'b1;
            end
            if (last_word) begin
              bus.st_done_pulse <= 1'b1;
              state             <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GLB_ST_DMA_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (bus.stream_data_valid && ((state == IDLE) || (state == LOAD)) &&
                 (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_glb_store_dma.sv
`default_nettype none
// Directed self-checking bench for glb_store_dma: each task drives one scenario
// and compares captured write packets against hand-computed values.
module tb_glb_store_dma;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  strb;
    logic [63:0] data;
    logic        done;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  wr_t  wq[$];
  int   done_cnt = 0;

  glb_store_dma_if bus ();

`ifdef GLB_ST_DMA_DROP_CNT_EN
  logic [15:0] drop_cnt;
  glb_store_dma dut (.clk(clk), .reset(reset), .bus(bus), .drop_cnt(drop_cnt));
`else
  glb_store_dma dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_en) wq.push_back({bus.wr_addr, bus.wr_strb, bus.wr_data, bus.st_done_pulse});
      if (bus.st_done_pulse) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hdr(input logic [21:0] a, input logic [20:0] n);
    bus.hdr_start_addr = a;
    bus.hdr_num_words  = n;
    bus.hdr_push       = 1'b1;
    tick();
    bus.hdr_push       = 1'b0;
  endtask

  task automatic send_words(input logic [127:0] ws, input int n);
    for (int i = 0; i < n; i++) begin
      bus.stream_data       = ws[16*i +: 16];
      bus.stream_data_valid = 1'b1;
      tick();
    end
    bus.stream_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
    tests++;
    if (bus.wr_strb !== 8'h00) begin fails++; $display("FAIL reset_wr_strb got %h want 00", bus.wr_strb); end
    tests++;
    if (bus.wr_addr !== 22'h0) begin fails++; $display("FAIL reset_wr_addr got %h want 0", bus.wr_addr); end
    tests++;
    if (bus.wr_data !== 64'h0) begin fails++; $display("FAIL reset_wr_data got %h want 0", bus.wr_data); end
    tests++;
    if (bus.st_done_pulse !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.st_done_pulse); end
    tests++;
    if (bus.hdr_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", bus.hdr_full); end
    tests++;
    if (bus.hdr_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.hdr_count); end
    tests++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_aligned();
    int  base = wq.size();
    int  d0   = done_cnt;
    wr_t exp;
    push_hdr(22'h000100, 21'd4);
    tick(); tick();
    send_words(128'h4444_3333_2222_1111, 4);
    tick(); tick();
    exp = {22'h000100, 8'hFF, 64'h4444_3333_2222_1111, 1'b1};
    if (wq.size() - base !== 1) begin fails++; $display("FAIL aligned_nwr got %0d want 1", wq.size() - base); end
    tests++;
    if (wq[base] !== exp) begin fails++; $display("FAIL aligned_wr got %h want %h", wq[base], exp); end
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL aligned_done got %0d want 1", done_cnt - d0); end
    tests++;
  endtask

  task automatic test_unaligned();
    int  base = wq.size();
    wr_t e1, e2;
    push_hdr(22'h000106, 21'd3);
    tick(); tick();
    send_words(128'hCCCC_BBBB_AAAA, 3);
    tick(); tick();
    e1 = {22'h000100, 8'hC0, 64'hAAAA_0000_0000_0000, 1'b0};
    e2 = {22'h000108, 8'h0F, 64'h0000_0000_CCCC_BBBB, 1'b1};
    if (wq.size() - base !== 2) begin fails++; $display("FAIL unaligned_nwr got %0d want 2", wq.size() - base); end
    tests++;
    if (wq[base] !== e1) begin fails++; $display("FAIL unaligned_wr1 got %h want %h", wq[base], e1); end
    tests++;
    if (wq[base+1] !== e2) begin fails++; $display("FAIL unaligned_wr2 got %h want %h", wq[base+1], e2); end
    tests++;
  endtask

  task automatic test_wrap();
    int  base = wq.size();
    wr_t e1, e2;
    push_hdr(22'h3FFFF8, 21'd8);
    tick(); tick();
    send_words(128'h0008_0007_0006_0005_0004_0003_0002_0001, 8);
    tick(); tick();
    e1 = {22'h3FFFF8, 8'hFF, 64'h0004_0003_0002_0001, 1'b0};
    e2 = {22'h000000, 8'hFF, 64'h0008_0007_0006_0005, 1'b1};
    if (wq.size() - base !== 2) begin fails++; $display("FAIL wrap_nwr got %0d want 2", wq.size() - base); end
    tests++;
    if (wq[base] !== e1) begin fails++; $display("FAIL wrap_wr1 got %h want %h", wq[base], e1); end
    tests++;
    if (wq[base+1] !== e2) begin fails++; $display("FAIL wrap_wr2 got %h want %h", wq[base+1], e2); end
    tests++;
  endtask

  task automatic test_zero_len();
    int  base = wq.size();
    int  d0   = done_cnt;
    wr_t exp;
    push_hdr(22'h000040, 21'd0);
    repeat (4) tick();
    if (wq.size() !== base) begin fails++; $display("FAIL zero_nwr got %0d want 0", wq.size() - base); end
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL zero_done got %0d want 1", done_cnt - d0); end
    tests++;
    push_hdr(22'h000048, 21'd2);
    tick(); tick();
    send_words(128'h6666_5555, 2);
    tick(); tick();
    exp = {22'h000048, 8'h0F, 64'h0000_0000_6666_5555, 1'b1};
    if (wq[base] !== exp) begin fails++; $display("FAIL zero_next_wr got %h want %h", wq[base], exp); end
    tests++;
  endtask

  task automatic test_queue_full();
    int          base = wq.size();
    int          d0   = done_cnt;
    logic [127:0] ws;
    wr_t         exp;
    push_hdr(22'h000200, 21'd4);
    tick(); tick();
    if (bus.hdr_count !== 3'd0) begin fails++; $display("FAIL qfull_start_count got %0d want 0", bus.hdr_count); end
    tests++;
    for (int h = 1; h <= 4; h++) push_hdr(22'h000300 + 22'(8 * (h - 1)), 21'd4);
    if (bus.hdr_full !== 1'b1) begin fails++; $display("FAIL qfull_full got %b want 1", bus.hdr_full); end
    tests++;
    push_hdr(22'h000400, 21'd4);
    if (bus.hdr_count !== 3'd4) begin fails++; $display("FAIL qfull_count got %0d want 4", bus.hdr_count); end
    tests++;
    for (int h = 0; h <= 4; h++) begin
      ws = '0;
      for (int i = 0; i < 4; i++) ws[16*i +: 16] = 16'(16'h1000 * h + i);
      if (h != 0) begin tick(); tick(); end
      send_words(ws, 4);
    end
    tick(); tick();
    if (wq.size() - base !== 5) begin fails++; $display("FAIL qfull_nwr got %0d want 5", wq.size() - base); end
    tests++;
    for (int h = 0; h <= 4; h++) begin
      ws = '0;
      for (int i = 0; i < 4; i++) ws[16*i +: 16] = 16'(16'h1000 * h + i);
      exp = {(h == 0) ? 22'h000200 : 22'h000300 + 22'(8 * (h - 1)), 8'hFF, ws[63:0], 1'b1};
      if (wq[base+h] !== exp) begin fails++; $display("FAIL qfull_wr%0d got %h want %h", h, wq[base+h], exp); end
      tests++;
    end
    if (done_cnt - d0 !== 5) begin fails++; $display("FAIL qfull_done got %0d want 5", done_cnt - d0); end
    tests++;
    if (bus.hdr_count !== 3'd0) begin fails++; $display("FAIL qfull_end_count got %0d want 0", bus.hdr_count); end
    tests++;
  endtask

  task automatic test_reset_mid();
    int base = wq.size();
    int d0   = done_cnt;
    push_hdr(22'h000000, 21'd4);
    tick(); tick();
    send_words(128'h2222_1111, 2);
    push_hdr(22'h000008, 21'd4);
    if (bus.hdr_count !== 3'd1) begin fails++; $display("FAIL rmid_pre_count got %0d want 1", bus.hdr_count); end
    tests++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    if (bus.hdr_count !== 3'd0) begin fails++; $display("FAIL rmid_count got %0d want 0", bus.hdr_count); end
    tests++;
`ifdef GLB_ST_DMA_DROP_CNT_EN
    if (drop_cnt !== 16'd0) begin fails++; $display("FAIL rmid_drop0 got %0d want 0", drop_cnt); end
    tests++;
    send_words(128'h3333_3333_3333, 3);
    if (drop_cnt !== 16'd3) begin fails++; $display("FAIL rmid_drop3 got %0d want 3", drop_cnt); end
    tests++;
`endif
    repeat (6) tick();
    if (wq.size() !== base) begin fails++; $display("FAIL rmid_nwr got %0d want 0", wq.size() - base); end
    tests++;
    if (done_cnt !== d0) begin fails++; $display("FAIL rmid_done got %0d want 0", done_cnt - d0); end
    tests++;
  endtask

  initial begin
    bus.hdr_push          = 1'b0;
    bus.hdr_start_addr    = '0;
    bus.hdr_num_words     = '0;
    bus.stream_data       = '0;
    bus.stream_data_valid = 1'b0;
    test_reset();
    test_aligned();
    test_unaligned();
    test_wrap();
    test_zero_len();
    test_queue_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
